mmss_timer_core: RTL and testbench
==================================

# mmss_timer_core

Parametrised successor to the current stopwatch counter: a minutes:seconds timer core that counts up (stopwatch) or down (countdown with expiry), supports field adjust, and optionally captures a lap value. Sits between the clock divider (consumes its 1 Hz and 2 Hz strobes) and the seven-segment display module (drives its minutes/seconds inputs). Button inputs are raw and asynchronous; the block synchronises them and detects their edges itself.

## Interface
- MAX_MIN, default 59: largest minutes value; minutes wrap/borrow at this bound.
- SYNC_STAGES, default 2: flop stages per button synchroniser (minimum 2).
- Derived localparam MIN_W = $clog2(MAX_MIN+1).

- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- tick_1hz  in  1  one-clk-wide count strobe.
- tick_2hz  in  1  one-clk-wide adjust-rate strobe.
- pause  in  1  raw button; rising edge toggles run/pause.
- adjust  in  1  raw level switch; high = adjust mode.
- select  in  1  raw level switch; 0 = adjust seconds, 1 = adjust minutes.
- count_down  in  1  raw level switch; 1 = countdown, 0 = count up.
- lap  in  1  raw button; rising edge toggles lap hold (feature-gated).
- minutes  out  MIN_W  displayed minutes.
- seconds  out  6  displayed seconds, 0..59.
- running  out  1  high in RUN.
- expired  out  1  high in EXPIRED.
- lap_active  out  1  high while display is frozen on a lap value.

## Operation
- States: PAUSED, RUN, ADJUST, EXPIRED. Reset -> PAUSED, count 00:00, all flags 0, lap hold cleared.
- PAUSED: pause edge -> RUN, except countdown at 00:00 stays PAUSED. adjust high -> ADJUST.
- RUN: on tick_1hz, up mode: seconds+1; 59 -> 0 with minutes+1; MAX_MIN:59 -> 00:00 and keep running. Down mode: seconds-1; 0 -> 59 with minutes-1; a tick taking the value to 00:00 moves to EXPIRED. pause edge -> PAUSED. adjust high -> ADJUST.
- ADJUST: tick_1hz ignored. On tick_2hz, selected field +1 (seconds wrap 59->0, minutes wrap MAX_MIN->0, no carry between fields). adjust low -> PAUSED. pause edges ignored.
- EXPIRED: value held at 00:00. pause edge -> PAUSED (expired clears). adjust high -> ADJUST.
- count_down is sampled on every tick; switching mid-run takes effect on the next tick, no value change at the switch.
- Priority when events coincide in one cycle: adjust > pause edge > tick. A tick coinciding with a pause edge in RUN is dropped.

## Timing
- Button/switch to internal effect: SYNC_STAGES cycles synchronisation + 1 cycle edge detect; state changes on the following clk edge.
- Tick to output: outputs are registered; new value visible one cycle after the strobe cycle.
- running/expired are decoded from the registered state, same cycle as the state.
- rst mid-operation: next clk returns everything to reset values, synchroniser flops cleared to 0 (no spurious edge after reset since all inputs start from 0 history).

## Configuration
- LAP_CAPTURE_EN defined: lap edge in RUN latches the live count into a lap register and sets lap_active; minutes/seconds show the lap register while counting continues internally; a second lap edge clears lap_active. Leaving RUN (pause, adjust, expiry) clears lap_active. Lap edges outside RUN ignored.
- Not defined: lap input unused, lap_active tied 0, minutes/seconds always show the live count; no lap register synthesised.

## Structure
- Shared package timer_pkg: state enum (PAUSED, RUN, ADJUST, EXPIRED), SEC_MAX = 59, SEC_W = 6.
- One sub-module: btn_sync_edge (SYNC_STAGES synchroniser plus rising-edge pulse and synchronised level out), instantiated once per raw input.
- Core holds state register, counter with carry/borrow logic, optional lap register.

## Test plan
- Reset, pause edge, 61 tick_1hz in up mode -> 01:01, running=1; MAX_MIN=2 at 02:59 plus one tick -> 00:00, still running.
- Adjust high, select=1, 3 tick_2hz, select=0, 5 tick_2hz, adjust low, count_down=1, pause, 2 ticks -> 03:03; continue to 00:00 -> expired=1, further ticks leave 00:00.
- Pause edge and tick_1hz in the same cycle in RUN at 00:10 -> PAUSED, value stays 00:10.
- Countdown at 00:00 in PAUSED, pause edge -> stays PAUSED, running=0; EXPIRED plus pause edge -> PAUSED, expired=0.
- LAP_CAPTURE_EN: run to 00:05, lap edge, 4 ticks -> display 00:05, lap_active=1; lap edge -> display 00:09. Without macro, same stimulus -> display 00:09 throughout, lap_active=0.
- rst asserted mid-RUN at 00:42 with adjust held high -> next cycle 00:00, PAUSED; after rst release, ADJUST entered only after SYNC_STAGES+2 cycles.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared types and constants for the minutes:seconds timer core.
package timer_pkg;

  typedef enum logic [1:0] {
    PAUSED  = 2'd0,
    RUN     = 2'd1,
    ADJUST  = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  localparam int unsigned SEC_MAX = 59;
  localparam int unsigned SEC_W   = 6;

endpackage

// File: rtl/btn_sync_edge.sv
// Synchroniser for one raw asynchronous input, with a registered level
// and a one-cycle rising-edge pulse. All history flops clear on reset.
module btn_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync  <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      sync  <= {sync[SYNC_STAGES-2:0], din};
      level <= sync[SYNC_STAGES-1];
      rise  <= sync[SYNC_STAGES-1] & ~level;
    end
  end

endmodule

// File: rtl/mmss_timer_core.sv
// Minutes:seconds stopwatch / countdown core with field adjust.
// Define LAP_CAPTURE_EN to build the lap-hold display register.
module mmss_timer_core
  import timer_pkg::*;
#(
  parameter  int unsigned MAX_MIN     = 59,
  parameter  int unsigned SYNC_STAGES = 2,
  localparam int unsigned MIN_W       = $clog2(MAX_MIN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_1hz,
  input  logic             tick_2hz,
  input  logic             pause,
  input  logic             adjust,
  input  logic             select,
  input  logic             count_down,
  input  logic             lap,
  output logic [MIN_W-1:0] minutes,
  output logic [SEC_W-1:0] seconds,
  output logic             running,
  output logic             expired,
  output logic             lap_active
);

  localparam logic [MIN_W-1:0] MIN_TOP = MIN_W'(MAX_MIN);
  localparam logic [SEC_W-1:0] SEC_TOP = SEC_W'(SEC_MAX);

  logic pause_lvl, pause_e;
  logic adj, adj_e;
  logic sel, sel_e;
  logic dn, dn_e;

  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_pause (
    .clk(clk), .rst(rst), .din(pause), .level(pause_lvl), .rise(pause_e));
  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_adjust (
    .clk(clk), .rst(rst), .din(adjust), .level(adj), .rise(adj_e));
  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_select (
    .clk(clk), .rst(rst), .din(select), .level(sel), .rise(sel_e));
  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_count_down (
    .clk(clk), .rst(rst), .din(count_down), .level(dn), .rise(dn_e));

  state_t           state, state_n;
  logic [MIN_W-1:0] cnt_min, min_n;
  logic [SEC_W-1:0] cnt_sec, sec_n;
  logic             zero;

  assign zero = (cnt_min == '0) && (cnt_sec == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= PAUSED;
      cnt_min <= '0;
      cnt_sec <= '0;
    end else begin
      state   <= state_n;
      cnt_min <= min_n;
      cnt_sec <= sec_n;
    end
  end

  // Branch order encodes the adjust > pause edge > tick priority.
  always_comb begin
    state_n = state;
    min_n   = cnt_min;
    sec_n   = cnt_sec;
    unique case (state)
      PAUSED: begin
        if (adj)
          state_n = ADJUST;
        else if (pause_e && !(dn && zero))
          state_n = RUN;
      end
      RUN: begin
        if (adj) begin
          state_n = ADJUST;
        end else if (pause_e) begin
          state_n = PAUSED;
        end else if (tick_1hz) begin
          if (!dn) begin
            if (cnt_sec == SEC_TOP) begin
              sec_n = '0;
              min_n = (cnt_min == MIN_TOP) ? '0 : cnt_min + MIN_W'(1);
            end else begin
              sec_n = cnt_sec + SEC_W'(1);
            end
          end else begin
            if (cnt_sec == '0) begin
              sec_n = SEC_TOP;
              min_n = (cnt_min == '0) ? MIN_TOP : cnt_min - MIN_W'(1);
            end else begin
              sec_n = cnt_sec - SEC_W'(1);
            end
            if ((min_n == '0) && (sec_n == '0))
              state_n = EXPIRED;
          end
        end
      end
      ADJUST: begin
        if (!adj) begin
          state_n = PAUSED;
        end else if (tick_2hz) begin
          if (sel)
            min_n = (cnt_min == MIN_TOP) ? '0 : cnt_min + MIN_W'(1);
          else
            sec_n = (cnt_sec == SEC_TOP) ? '0 : cnt_sec + SEC_W'(1);
        end
      end
      EXPIRED: begin
        min_n = '0;
        sec_n = '0;
        if (adj)
          state_n = ADJUST;
        else if (pause_e)
          state_n = PAUSED;
      end
      default: state_n = PAUSED;
    endcase
  end

  assign running = (state == RUN);
  assign expired = (state == EXPIRED);

`ifdef LAP_CAPTURE_EN
  logic             lap_lvl, lap_e;
  logic             lap_on;
  logic [MIN_W-1:0] lap_min;
  logic [SEC_W-1:0] lap_sec;

  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_lap (
    .clk(clk), .rst(rst), .din(lap), .level(lap_lvl), .rise(lap_e));

  always_ff @(posedge clk) begin
    if (rst) begin
      lap_on  <= 1'b0;
      lap_min <= '0;
      lap_sec <= '0;
    end else if (state_n != RUN) begin
      lap_on <= 1'b0;
    end else if ((state == RUN) && lap_e) begin
      lap_on <= ~lap_on;
      if (!lap_on) begin
        lap_min <= cnt_min;
        lap_sec <= cnt_sec;
      end
    end
  end

  assign minutes    = lap_on ? lap_min : cnt_min;
  assign seconds    = lap_on ? lap_sec : cnt_sec;
  assign lap_active = lap_on;

  logic unused_ok;
  assign unused_ok = &{1'b0, pause_lvl, adj_e, sel_e, dn_e, lap_lvl};
`else
  assign minutes    = cnt_min;
  assign seconds    = cnt_sec;
  assign lap_active = 1'b0;

  logic unused_ok;
  assign unused_ok = &{1'b0, pause_lvl, adj_e, sel_e, dn_e, lap};
`endif

endmodule

// File: tb/tb_mmss_timer_core.sv
// Directed bench for mmss_timer_core; lap expectations follow LAP_CAPTURE_EN.
module tb_mmss_timer_core;

  localparam int unsigned SYNC = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, tick_1hz, tick_2hz, pause, adjust, select, count_down, lap;
  logic [5:0] minutes, seconds;
  logic       running, expired, lap_active;

  logic       tick_b, pause_b;
  logic [1:0] minutes_b;
  logic [5:0] seconds_b;
  logic       running_b, expired_b, lap_active_b;

  mmss_timer_core #(.MAX_MIN(59), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .tick_2hz(tick_2hz),
    .pause(pause), .adjust(adjust), .select(select), .count_down(count_down),
    .lap(lap), .minutes(minutes), .seconds(seconds), .running(running),
    .expired(expired), .lap_active(lap_active));

  mmss_timer_core #(.MAX_MIN(2), .SYNC_STAGES(SYNC)) dut_b (
    .clk(clk), .rst(rst), .tick_1hz(tick_b), .tick_2hz(1'b0),
    .pause(pause_b), .adjust(1'b0), .select(1'b0), .count_down(1'b0),
    .lap(1'b0), .minutes(minutes_b), .seconds(seconds_b), .running(running_b),
    .expired(expired_b), .lap_active(lap_active_b));

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press_pause();
    pause = 1'b1; step(SYNC + 2);
    pause = 1'b0; step(SYNC + 2);
  endtask

  task automatic press_pause_b();
    pause_b = 1'b1; step(SYNC + 2);
    pause_b = 1'b0; step(SYNC + 2);
  endtask

  task automatic press_lap();
    lap = 1'b1; step(SYNC + 2);
    lap = 1'b0; step(SYNC + 2);
  endtask

  task automatic tick1(input int n);
    repeat (n) begin
      tick_1hz = 1'b1; step(1);
      tick_1hz = 1'b0; step(1);
    end
  endtask

  task automatic tick2(input int n);
    repeat (n) begin
      tick_2hz = 1'b1; step(1);
      tick_2hz = 1'b0; step(1);
    end
  endtask

  task automatic tick_bn(input int n);
    repeat (n) begin
      tick_b = 1'b1; step(1);
      tick_b = 1'b0; step(1);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; step(2);
    rst = 1'b0; step(1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst = 1'b1; tick_1hz = 0; tick_2hz = 0; pause = 0; adjust = 0;
    select = 0; count_down = 0; lap = 0; tick_b = 0; pause_b = 0;
    step(3);
    rst = 1'b0; step(1);

    check("rst_min", minutes, 0);
    check("rst_sec", seconds, 0);
    check("rst_run", running, 0);
    check("rst_exp", expired, 0);
    check("rst_lap", lap_active, 0);

    // Count up past a minute boundary
    press_pause();
    check("up_run", running, 1);
    tick1(61);
    check("up_min", minutes, 1);
    check("up_sec", seconds, 1);
    check("up_run2", running, 1);

    // MAX_MIN=2 instance wraps 02:59 -> 00:00 and keeps running
    press_pause_b();
    tick_bn(179);
    check("wrap_pre_min", minutes_b, 2);
    check("wrap_pre_sec", seconds_b, 59);
    tick_bn(1);
    check("wrap_min", minutes_b, 0);
    check("wrap_sec", seconds_b, 0);
    check("wrap_run", running_b, 1);

    // Adjust fields, then count down to expiry
    do_reset();
    adjust = 1'b1; step(SYNC + 2);
    select = 1'b1; step(SYNC + 2);
    tick2(3);
    select = 1'b0; step(SYNC + 2);
    tick2(5);
    check("adj_min", minutes, 3);
    check("adj_sec", seconds, 5);
    check("adj_run", running, 0);
    tick1(2);
    check("adj_ign1hz", seconds, 5);
    adjust = 1'b0; step(SYNC + 2);
    count_down = 1'b1; step(SYNC + 2);
    press_pause();
    check("dn_run", running, 1);
    tick1(2);
    check("dn_min", minutes, 3);
    check("dn_sec", seconds, 3);
    tick1(182);
    check("dn_last_sec", seconds, 1);
    check("dn_last_exp", expired, 0);
    tick1(1);
    check("exp_min", minutes, 0);
    check("exp_sec", seconds, 0);
    check("exp_flag", expired, 1);
    check("exp_run", running, 0);
    tick1(3);
    check("exp_hold_sec", seconds, 0);
    check("exp_hold_min", minutes, 0);
    check("exp_hold_flag", expired, 1);

    // EXPIRED + pause -> PAUSED; countdown at zero refuses to start
    press_pause();
    check("exp_clr", expired, 0);
    check("exp_clr_run", running, 0);
    press_pause();
    check("zero_dn_run", running, 0);
    check("zero_dn_exp", expired, 0);

    // Pause edge and tick in the same cycle: tick dropped
    count_down = 1'b0; step(SYNC + 2);
    press_pause();
    tick1(10);
    check("pt_pre", seconds, 10);
    pause = 1'b1; step(SYNC + 1);
    tick_1hz = 1'b1; step(1);
    tick_1hz = 1'b0; pause = 1'b0;
    check("pt_run", running, 0);
    check("pt_sec", seconds, 10);
    step(SYNC + 3);
    tick1(2);
    check("pt_hold", seconds, 10);

    // Lap hold
    do_reset();
    press_pause();
    tick1(5);
    press_lap();
    tick1(4);
`ifdef LAP_CAPTURE_EN
    check("lap_hold_sec", seconds, 5);
    check("lap_hold_act", lap_active, 1);
`else
    check("lap_hold_sec", seconds, 9);
    check("lap_hold_act", lap_active, 0);
`endif
    press_lap();
    check("lap_rel_sec", seconds, 9);
    check("lap_rel_act", lap_active, 0);

    // Reset mid-run with adjust held; ADJUST entry latency after release
    do_reset();
    press_pause();
    tick1(42);
    check("mid_sec", seconds, 42);
    rst = 1'b1; adjust = 1'b1; step(1);
    check("mid_rst_sec", seconds, 0);
    check("mid_rst_min", minutes, 0);
    check("mid_rst_run", running, 0);
    rst = 1'b0; tick_2hz = 1'b1;
    step(SYNC + 2);
    check("adj_lat_early", seconds, 0);
    step(1);
    check("adj_lat_entry", seconds, 1);
    tick_2hz = 1'b0; adjust = 1'b0;
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
